booth_arbiter: RTL and testbench

- Round-robin controller sharing one booth multiplier instance (ports X, Y, start, produs) among N_REQ requesters.
- Accepts one request at a time and latches that requester's operands.
- Drives the multiplier's start for a fixed number of cycles, then waits a fixed settle latency.
- Captures produs and returns it to the granted requester with a one-cycle done pulse.

---
 rtl/booth_arbiter.sv | 106 ++++++++++
 tb/tb_booth_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin sharing of one booth multiplier among N_REQ requesters,
// with fixed start-hold and settle timing before the product is captured.
module booth_arbiter #(
   parameter int N_REQ     = 4,
   parameter int START_CYC = 5,
   parameter int LAT       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   x_in,
   input  logic [8*N_REQ-1:0]   y_in,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [15:0]          result,
   output logic                 busy,
   output logic [7:0]           m_X,
   output logic [7:0]           m_Y,
   output logic                 m_start,
   input  logic [15:0]          m_produs
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2((START_CYC > LAT ? START_CYC : LAT) + 1);
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] ptr, ptr_n, id, id_n, k, j;
   logic [CW-1:0] cnt, cnt_n;
   logic [N_REQ-1:0] gnt_n, done_n;
   logic [15:0] result_n;
   logic [7:0] mx_n, my_n;
   logic start_n, found;
   logic [8*N_REQ-1:0] xs, ys;
   assign busy = state != IDLE;
   assign xs = x_in >> {k, 3'b000};
   assign ys = y_in >> {k, 3'b000};
   // descending scan so the lowest offset from ptr wins
   always_comb begin
      found = 1'b0;
      k = '0;
      j = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % N_REQ);
         if (req[j]) begin
            found = 1'b1;
            k = j;
         end
      end
   end
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      id_n     = id;
      cnt_n    = '0;
      gnt_n    = '0;
      done_n   = '0;
      result_n = result;
      mx_n     = m_X;
      my_n     = m_Y;
      start_n  = m_start;
      case (state)
         IDLE: if (found) begin
            state_n = START;
            gnt_n   = N_REQ'(1) << k;
            mx_n    = xs[7:0];
            my_n    = ys[7:0];
            start_n = 1'b1;
            id_n    = k;
            ptr_n   = IW'((int'(k) + 1) % N_REQ);
         end
         START: if (cnt == CW'(START_CYC - 1)) begin
            start_n = 1'b0;
            state_n = WAIT;
         end else cnt_n = cnt + 1'b1;
         WAIT: if (cnt == CW'(LAT - 1)) begin
            result_n = m_produs;
            done_n   = N_REQ'(1) << id;
            state_n  = DONE;
         end else cnt_n = cnt + 1'b1;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         id      <= '0;
         cnt     <= '0;
         gnt     <= '0;
         done    <= '0;
         result  <= '0;
         m_X     <= '0;
         m_Y     <= '0;
         m_start <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         id      <= id_n;
         cnt     <= cnt_n;
         gnt     <= gnt_n;
         done    <= done_n;
         result  <= result_n;
         m_X     <= mx_n;
         m_Y     <= my_n;
         m_start <= start_n;
      end
endmodule

// File: tb/tb_booth_arbiter.sv
// tb_booth_arbiter: directed and random requests checked cycle by cycle against a
// transaction-time reference model (cycles since grant) of the arbiter.
module tb_booth_arbiter;
   localparam int N = 4, S = 5, L = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [7:0] xv [N], yv [N];
   logic [8*N-1:0] x_in, y_in;
   logic [N-1:0] gnt, done;
   logic [15:0] result, m_produs;
   logic busy, m_start;
   logic [7:0] m_X, m_Y;
   int checks = 0, errors = 0;
   int t = -1, mptr = 0, mid = 0;
   logic [7:0] ex = 0, ey = 0;
   logic [15:0] res = 0;
   int gq[$];
   int f = 0;

   booth_arbiter #(.N_REQ(N), .START_CYC(S), .LAT(L)) dut (
      .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in), .gnt(gnt), .done(done),
      .result(result), .busy(busy), .m_X(m_X), .m_Y(m_Y), .m_start(m_start), .m_produs(m_produs)
   );

   always #5 clk = ~clk;
   assign x_in = {xv[3], xv[2], xv[1], xv[0]};
   assign y_in = {yv[3], yv[2], yv[1], yv[0]};
   // multiplier stand-in: product only valid once it has settled after start falls
   always @(posedge clk) f <= m_start ? 0 : (f > 1000 ? f : f + 1);
   assign m_produs = (!m_start && f >= L - 1) ? 16'($signed(m_X) * $signed(m_Y)) : 16'hDEAD;

   function automatic logic [15:0] prod(logic [7:0] a, logic [7:0] b);
      return 16'(int'($signed(a)) * int'($signed(b)));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      t = -1; mptr = 0; mid = 0; ex = 0; ey = 0; res = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) reset_model();
      else if (t < 0) begin
         for (int i = 0; i < N; i++) begin
            int c = (mptr + i) % N;
            if (req[c]) begin
               t = 0; mid = c; mptr = (c + 1) % N; ex = xv[c]; ey = yv[c];
               break;
            end
         end
      end else begin
         t++;
         if (t == S + L) res = prod(ex, ey);
         if (t > S + L) t = -1;
      end
      #1;
      chk("gnt", 32'(gnt), t == 0 ? 32'(1) << mid : 0);
      chk("done", 32'(done), t == S + L ? 32'(1) << mid : 0);
      chk("m_start", 32'(m_start), 32'(t >= 0 && t < S));
      chk("busy", 32'(busy), 32'(t >= 0));
      chk("result", 32'(result), 32'(res));
      chk("m_X", 32'(m_X), 32'(ex));
      chk("m_Y", 32'(m_Y), 32'(ey));
      for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin xv[i] = '0; yv[i] = '0; end
      do_reset();
      tick();
      // single request
      xv[0] = 8'd6; yv[0] = 8'd3; req = 4'b0001;
      tick();
      req = '0;
      repeat (15) tick();
      chk("single_result", 32'(result), 32'd18);
      // contention, each requester drops after its grant
      do_reset();
      gq.delete();
      for (int i = 0; i < N; i++) begin xv[i] = 8'(i + 1); yv[i] = 8'd6; end
      req = 4'b1111;
      repeat (62) begin tick(); req &= ~gnt; end
      chk("contention_count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4 && i < gq.size(); i++) chk("contention_order", 32'(gq[i]), 32'(i));
      chk("contention_last_result", 32'(result), 32'd24);
      // fairness with req[1] and req[3] held
      do_reset();
      gq.delete();
      req = 4'b1010;
      repeat (62) tick();
      req = '0;
      repeat (16) tick();
      chk("fair_count", 32'(gq.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < gq.size(); i++) chk("fair_order", 32'(gq[i]), (i % 2) ? 32'd3 : 32'd1);
      // async reset during WAIT
      do_reset();
      xv[2] = 8'd7; yv[2] = 8'd9; req = 4'b0100;
      tick();
      req = '0;
      repeat (9) tick();
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_start", 32'(m_start), 0);
      chk("rst_mx", 32'({m_X, m_Y}), 0);
      chk("rst_result", 32'(result), 0);
      reset_model();
      tick();
      rst = 1'b0;
      gq.delete();
      xv[1] = 8'd2; yv[1] = 8'd5; req = 4'b0110;
      tick();
      chk("rst_regrant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
      req = '0;
      repeat (16) tick();
      // operand sweep on requester 2
      yv[2] = 8'd6;
      for (int x = 0; x <= 11; x++) begin
         xv[2] = (x == 11) ? 8'hFD : 8'(x);
         req = 4'b0100;
         tick();
         req = '0;
         repeat (15) tick();
         chk("sweep_result", 32'(result), (x == 11) ? 32'h0000FFEE : 32'(6 * x));
      end
      // withdrawal while busy, then late arrival during WAIT
      gq.delete();
      xv[3] = 8'd3; yv[3] = 8'd3; req = 4'b1000;
      tick();
      req = 4'b0001;
      repeat (3) tick();
      req = '0;
      repeat (5) tick();
      req = 4'b0010;
      begin
         int n = 0;
         while (!gnt[1] && n < 30) begin tick(); n++; end
         chk("late_gnt", 32'(gnt[1]), 32'd1);
      end
      req = '0;
      repeat (16) tick();
      chk("withdraw_grants", 32'(gq.size()), 32'd2);
      // random traffic
      do_reset();
      repeat (1500) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && gnt[i]) req[i] = 1'b0;
            else if (req[i] && $urandom_range(0, 60) == 0) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i] = 1'b1; xv[i] = 8'($urandom); yv[i] = 8'($urandom);
            end
         end
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
